onewire_arbiter: RTL and testbench
==================================

Name: onewire_arbiter

Overview:
Two-master to one-slave Avalon MM arbiter that shares the single onewire peripheral register port (TX/RX data, waitrequest, interrupt) between two requesters, e.g. a Nios CPU and a hardware poll sequencer. It sits directly in front of the onewire instance. It performs round-robin arbitration with a registered grant and holds the grant until the transfer completes. It routes the peripheral interrupt to the master that issued the most recent write.

Parameters:
AAW, 1, Avalon address width
ADW, 32, Avalon data width
ABW, ADW/8, byte enable width (derived; not to be overridden)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_address  in  AAW  master 0 address
m0_byteenable  in  ABW  master 0 byte enables
m0_writedata  in  ADW  master 0 write data
m0_readdata  out  ADW  master 0 read data
m0_waitrequest  out  1  master 0 stall
m0_interrupt  out  1  master 0 interrupt
m1_read, m1_write, m1_address, m1_byteenable, m1_writedata, m1_readdata, m1_waitrequest, m1_interrupt: same directions, widths and meanings as the m0 ports, for master 1
s_read  out  1  slave read
s_write  out  1  slave write
s_address  out  AAW  slave address
s_byteenable  out  ABW  slave byte enables
s_writedata  out  ADW  slave write data
s_readdata  in  ADW  slave read data
s_waitrequest  in  1  slave stall
s_interrupt  in  1  slave interrupt

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- State register grant: IDLE, G0, G1. Additional registers: rr_last (last master served, 1 bit) and irq_owner (1 bit).
- Reset values: grant=IDLE, rr_last=1 (so m0 wins the first tie), irq_owner=0.
- Outputs during and after reset: s_read=s_write=0; s_address, s_byteenable, s_writedata = 0; m0_waitrequest = m1_waitrequest = 1; m*_readdata = 0; m*_interrupt = 0 while rst is high.
- reqN = mN_read | mN_write. doneN = (grant==GN) & reqN & ~s_waitrequest.
- IDLE:
  - only req0 -> G0; only req1 -> G1.
  - both -> the master other than rr_last.
  - none -> stay IDLE.
  - Arbitration latency: 1 cycle. A request seen at edge N reaches the slave after edge N+1.
- GN:
  - s_* command outputs = mN_* (combinational mux on the registered grant).
  - mN_waitrequest = s_waitrequest; mN_readdata = s_readdata.
  - The non-granted master: waitrequest=1, readdata=0.
- On doneN:
  - rr_last<=N.
  - If the transfer was a write, irq_owner<=N.
  - Next state = G(other) if the other master is requesting, else IDLE. No bubble cycle on a switch.
- Master deasserts its request while granted, without done (protocol violation): return to IDLE next cycle. rr_last is unchanged.
- Interrupt routing: mN_interrupt = s_interrupt & (irq_owner==N). A read transfer does not change irq_owner.
- Simultaneous read and write from one master: undefined. Treated as a write for irq_owner.
- Reset mid-transfer: grant forced to IDLE at that edge. The slave command drops on the following cycle. The master remains stalled.

Optional Feature:
Macro: ONEWIRE_ARB_LOCK_EN.
- Enabled: ports m0_lock and m1_lock (input, 1 bit) are added.
  - While mN_lock=1 and grant==GN, the grant is held after doneN even with no request, and even if the other master is requesting.
  - The grant is released only on a cycle where mN_lock=0 and reqN=0.
  - Purpose: an atomic reset-pulse + command-byte sequence on the 1-wire bus.
- Disabled: the ports are absent and behaviour is as specified above.

Decomposition:
- Package onewire_arb_pkg:
  - grant state encoding (IDLE=2'd0, G0=2'd1, G1=2'd2);
  - master index constants M0=1'b0, M1=1'b1.
- Sub-module onewire_arb_rr:
  - combinational 2-way round-robin pick;
  - inputs: req0, req1, rr_last;
  - outputs: valid, pick.

Test Plan:
1. Reset, then m0 writes "H" (8'h48) with s_waitrequest=0 -> s_write=1 with s_writedata=32'h48 one cycle after the request; m0_waitrequest low in that cycle; irq_owner=0.
2. m0 and m1 write 8'h41 and 8'h42 in the same cycle -> slave sees 8'h41 first, then 8'h42 in the next cycle with no idle cycle; m1_waitrequest=1 throughout the m0 transfer.
3. m1 writes "T"; s_interrupt is raised later -> m1_interrupt=1, m0_interrupt=0. m1 then reads 32'h54 -> m1_readdata=32'h54; interrupt routing is unchanged by the read.
4. s_waitrequest held high for 5 cycles during a G0 write -> m0_waitrequest high for 5 cycles; a pending m1 request is not granted until doneN.
5. Assert rst during a G1 transfer -> s_write=0 from the next cycle; grant=IDLE; both waitrequests=1; the next m0/m1 tie goes to m0.
6. (ONEWIRE_ARB_LOCK_EN) m0_lock=1 across two writes while m1 is requesting -> both m0 writes complete before the m1 grant, which follows the first cycle with m0_lock=0 and m0 idle.

Source files
------------

// File: rtl/onewire_arb_pkg.sv
// Shared types for the onewire two-master arbiter: grant encoding and master indices.
package onewire_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } grant_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    function automatic grant_t grant_of(input logic m);
        return m ? G1 : G0;
    endfunction

endpackage

// File: rtl/onewire_arb_rr.sv
// Two-way round-robin pick: on a tie the master other than rr_last wins.
module onewire_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic valid,
    output logic pick
);

    assign valid = req0 | req1;
    assign pick  = (req0 & req1) ? ~rr_last : req1;

endmodule

// File: rtl/onewire_arbiter.sv
// Two-master Avalon-MM arbiter in front of the onewire register port; registered round-robin grant.
// Optional ONEWIRE_ARB_LOCK_EN adds m0_lock/m1_lock to hold a grant across several transfers.
module onewire_arbiter
    import onewire_arb_pkg::*;
#(
    parameter  int AAW = 1,
    parameter  int ADW = 32,
    localparam int ABW = ADW / 8
) (
    input  logic           clk,
    input  logic           rst,
`ifdef ONEWIRE_ARB_LOCK_EN
    input  logic           m0_lock,
    input  logic           m1_lock,
`endif
    input  logic           m0_read,
    input  logic           m0_write,
    input  logic [AAW-1:0] m0_address,
    input  logic [ABW-1:0] m0_byteenable,
    input  logic [ADW-1:0] m0_writedata,
    output logic [ADW-1:0] m0_readdata,
    output logic           m0_waitrequest,
    output logic           m0_interrupt,
    input  logic           m1_read,
    input  logic           m1_write,
    input  logic [AAW-1:0] m1_address,
    input  logic [ABW-1:0] m1_byteenable,
    input  logic [ADW-1:0] m1_writedata,
    output logic [ADW-1:0] m1_readdata,
    output logic           m1_waitrequest,
    output logic           m1_interrupt,
    output logic           s_read,
    output logic           s_write,
    output logic [AAW-1:0] s_address,
    output logic [ABW-1:0] s_byteenable,
    output logic [ADW-1:0] s_writedata,
    input  logic [ADW-1:0] s_readdata,
    input  logic           s_waitrequest,
    input  logic           s_interrupt
);

    grant_t     grant, grant_nxt;
    logic       rr_last, irq_owner;
    logic [1:0] req, wr, lock;
    logic       cur, done, rr_valid, rr_pick;

    assign req = {m1_read | m1_write, m0_read | m0_write};
    assign wr  = {m1_write, m0_write};
`ifdef ONEWIRE_ARB_LOCK_EN
    assign lock = {m1_lock, m0_lock};
`else
    assign lock = 2'b00;
`endif

    assign cur  = (grant == G1);
    assign done = (grant != IDLE) & req[cur] & ~s_waitrequest;

    onewire_arb_rr u_rr (
        .req0    (req[0]),
        .req1    (req[1]),
        .rr_last (rr_last),
        .valid   (rr_valid),
        .pick    (rr_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= IDLE;
            rr_last   <= M1;
            irq_owner <= M0;
        end else begin
            grant <= grant_nxt;
            if (done) begin
                rr_last <= cur;
                if (wr[cur]) irq_owner <= cur;
            end
        end
    end

    // A switch after done goes straight to the other master, so there is no bubble cycle.
    always_comb begin
        grant_nxt = grant;
        case (grant)
            IDLE: if (rr_valid) grant_nxt = grant_of(rr_pick);
            G0, G1: begin
                if (lock[cur])     grant_nxt = grant;
                else if (done)     grant_nxt = req[~cur] ? grant_of(~cur) : IDLE;
                else if (!req[cur]) grant_nxt = IDLE;
            end
            default: grant_nxt = IDLE;
        endcase
    end

    // Masters stay stalled while rst is high, even if the slave is still finishing a command.
    always_comb begin
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_address      = '0;
        s_byteenable   = '0;
        s_writedata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (grant)
            G0: begin
                s_read         = m0_read;
                s_write        = m0_write;
                s_address      = m0_address;
                s_byteenable   = m0_byteenable;
                s_writedata    = m0_writedata;
                m0_waitrequest = s_waitrequest | rst;
                m0_readdata    = s_readdata;
            end
            G1: begin
                s_read         = m1_read;
                s_write        = m1_write;
                s_address      = m1_address;
                s_byteenable   = m1_byteenable;
                s_writedata    = m1_writedata;
                m1_waitrequest = s_waitrequest | rst;
                m1_readdata    = s_readdata;
            end
            default: ;
        endcase
        m0_interrupt = s_interrupt & ~rst & (irq_owner == M0);
        m1_interrupt = s_interrupt & ~rst & (irq_owner == M1);
    end

endmodule

// File: tb/tb_onewire_arbiter.sv
// Directed bench for onewire_arbiter: per-cycle vector table plus alternation and lock sequences.
module tb_onewire_arbiter;

    localparam int AAW = 1;
    localparam int ADW = 32;
    localparam int ABW = ADW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
`ifdef ONEWIRE_ARB_LOCK_EN
    logic           m0_lock = 1'b0, m1_lock = 1'b0;
`endif
    logic           m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [AAW-1:0] m0_address = 1'b0, m1_address = 1'b1;
    logic [ABW-1:0] m0_byteenable = 4'h1, m1_byteenable = 4'hF;
    logic [ADW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [ADW-1:0] m0_readdata, m1_readdata;
    logic           m0_waitrequest, m1_waitrequest, m0_interrupt, m1_interrupt;
    logic           s_read, s_write;
    logic [AAW-1:0] s_address;
    logic [ABW-1:0] s_byteenable;
    logic [ADW-1:0] s_writedata;
    logic [ADW-1:0] s_readdata = '0;
    logic           s_waitrequest = 1'b0, s_interrupt = 1'b0;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    onewire_arbiter #(.AAW(AAW), .ADW(ADW)) dut (
        .clk(clk), .rst(rst),
`ifdef ONEWIRE_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest), .m0_interrupt(m0_interrupt),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest), .m1_interrupt(m1_interrupt),
        .s_read(s_read), .s_write(s_write), .s_address(s_address),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest), .s_interrupt(s_interrupt)
    );

    typedef struct {
        logic        rst, r0, w0;
        logic [7:0]  d0;
        logic        r1, w1;
        logic [7:0]  d1;
        logic        sw;
        logic [31:0] srd;
        logic        irq;
        logic [1:0]  g;
        logic        esr, esw;
        logic [7:0]  esd;
        logic        ew0, ew1;
        logic [31:0] erd0, erd1;
        logic        ei0, ei1;
    } vec_t;

    vec_t tbl[64];
    int   n = 0;

    function automatic vec_t mk(int rs, int r0, int w0, int d0, int r1, int w1, int d1,
                                int sw, int srd, int irq, int g, int esr, int esw, int esd,
                                int ew0, int ew1, int erd0, int erd1, int ei0, int ei1);
        vec_t v;
        v.rst = 1'(rs);   v.r0 = 1'(r0);   v.w0 = 1'(w0);   v.d0 = 8'(d0);
        v.r1 = 1'(r1);    v.w1 = 1'(w1);   v.d1 = 8'(d1);   v.sw = 1'(sw);
        v.srd = 32'(srd); v.irq = 1'(irq); v.g = 2'(g);     v.esr = 1'(esr);
        v.esw = 1'(esw);  v.esd = 8'(esd); v.ew0 = 1'(ew0); v.ew1 = 1'(ew1);
        v.erd0 = 32'(erd0); v.erd1 = 32'(erd1); v.ei0 = 1'(ei0); v.ei1 = 1'(ei1);
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[n] = v;
        n++;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic cyc(input logic r0, input logic w0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [7:0] d1, input logic l0);
        @(posedge clk);
        #1;
        rst = 1'b0; s_waitrequest = 1'b0; s_readdata = '0; s_interrupt = 1'b0;
        m0_read = r0; m0_write = w0; m0_writedata = {24'h0, d0};
        m1_read = r1; m1_write = w1; m1_writedata = {24'h0, d1};
`ifdef ONEWIRE_ARB_LOCK_EN
        m0_lock = l0;
`else
        if (l0) $display("lock requested without lock support");
`endif
        @(negedge clk);
    endtask

    initial begin
        // rst r0 w0 d0 r1 w1 d1 sw srd irq | g sr sw sd wr0 wr1 rd0 rd1 i0 i1
        add(mk(1,0,0,0,    0,0,0,    0,'hdead,1, 0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,0,0,    0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,1,'h48, 0,0,0,    0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,1,'h48, 0,0,0,    0,0,0,      1,0,1,'h48, 0,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,0,0,    0,0,1,      0,0,0,0,    1,1,0,0,   1,0));
        add(mk(1,0,0,0,    0,0,0,    0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,1,'h41, 0,1,'h42, 0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,1,'h41, 0,1,'h42, 0,0,0,      1,0,1,'h41, 0,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,1,'h42, 0,0,0,      2,0,1,'h42, 1,0,0,0,   0,0));
        add(mk(0,0,0,0,    0,1,'h54, 0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,1,'h54, 0,0,0,      2,0,1,'h54, 1,0,0,0,   0,0));
        add(mk(0,0,0,0,    0,0,0,    0,0,1,      0,0,0,0,    1,1,0,0,   0,1));
        add(mk(0,0,0,0,    1,0,0,    0,'h54,1,   0,0,0,0,    1,1,0,0,   0,1));
        add(mk(0,0,0,0,    1,0,0,    0,'h54,1,   2,1,0,0,    1,0,0,'h54,0,1));
        add(mk(0,0,0,0,    0,0,0,    0,0,1,      0,0,0,0,    1,1,0,0,   0,1));
        add(mk(0,0,1,'h55, 0,0,0,    1,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        for (int k = 0; k < 5; k++)
            add(mk(0,0,1,'h55, 0,1,'h66, 1,0,0,  1,0,1,'h55, 1,1,0,0,   0,0));
        add(mk(0,0,1,'h55, 0,1,'h66, 0,0,0,      1,0,1,'h55, 0,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,1,'h66, 1,0,0,      2,0,1,'h66, 1,1,0,0,   0,0));
        add(mk(1,0,0,0,    0,1,'h66, 1,0,1,      2,0,1,'h66, 1,1,0,0,   0,0));
        add(mk(0,0,1,'h77, 0,1,'h88, 0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,1,'h77, 0,1,'h88, 0,0,0,      1,0,1,'h77, 0,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,1,'h88, 0,0,0,      2,0,1,'h88, 1,0,0,0,   0,0));
        add(mk(0,1,0,0,    0,0,0,    1,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,1,0,0,    0,0,0,    1,'h99,0,   1,1,0,0,    1,1,'h99,0,0,0));
        add(mk(0,0,0,0,    0,0,0,    1,'h99,0,   1,0,0,0,    1,1,'h99,0,0,0));
        add(mk(0,0,1,'h11, 0,1,'h22, 0,0,0,      0,0,0,0,    1,1,0,0,   0,0));
        add(mk(0,0,1,'h11, 0,1,'h22, 0,0,0,      1,0,1,'h11, 0,1,0,0,   0,0));
        add(mk(0,0,0,0,    0,1,'h22, 0,0,0,      2,0,1,'h22, 1,0,0,0,   0,0));
        add(mk(0,0,0,0,    0,0,0,    0,0,0,      0,0,0,0,    1,1,0,0,   0,0));

        for (int i = 0; i < n; i++) begin
            if (i > 0) @(posedge clk);
            #1;
            rst = tbl[i].rst;
            m0_read = tbl[i].r0; m0_write = tbl[i].w0; m0_writedata = {24'h0, tbl[i].d0};
            m1_read = tbl[i].r1; m1_write = tbl[i].w1; m1_writedata = {24'h0, tbl[i].d1};
            s_waitrequest = tbl[i].sw; s_readdata = tbl[i].srd; s_interrupt = tbl[i].irq;
            @(negedge clk);
            chk("s_read",   i, 32'(s_read),  32'(tbl[i].esr));
            chk("s_write",  i, 32'(s_write), 32'(tbl[i].esw));
            chk("s_wdata",  i, s_writedata,  32'(tbl[i].esd));
            chk("s_addr",   i, 32'(s_address), (tbl[i].g == 2'd2) ? 32'd1 : 32'd0);
            chk("s_be",     i, 32'(s_byteenable),
                (tbl[i].g == 2'd1) ? 32'h1 : (tbl[i].g == 2'd2) ? 32'hF : 32'h0);
            chk("m0_wait",  i, 32'(m0_waitrequest), 32'(tbl[i].ew0));
            chk("m1_wait",  i, 32'(m1_waitrequest), 32'(tbl[i].ew1));
            chk("m0_rdata", i, m0_readdata, tbl[i].erd0);
            chk("m1_rdata", i, m1_readdata, tbl[i].erd1);
            chk("m0_irq",   i, 32'(m0_interrupt), 32'(tbl[i].ei0));
            chk("m1_irq",   i, 32'(m1_interrupt), 32'(tbl[i].ei1));
        end

        // Both masters stream writes: grants alternate back-to-back with no idle cycle.
        cyc(0,1,8'hA0, 0,1,8'hB0, 0);
        chk("alt_idle", 0, 32'(s_write), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            cyc(0,1,8'hA0, 0,1,8'hB0, 0);
            chk("alt_write", k, 32'(s_write), 32'd1);
            chk("alt_addr",  k, 32'(s_address), (k % 2 == 1) ? 32'd0 : 32'd1);
            chk("alt_wdata", k, s_writedata, (k % 2 == 1) ? 32'hA0 : 32'hB0);
            chk("alt_m0w",   k, 32'(m0_waitrequest), (k % 2 == 1) ? 32'd0 : 32'd1);
        end
        cyc(0,0,8'h00, 0,0,8'h00, 0);
        chk("alt_drop", 0, 32'(s_write), 32'd0);
        cyc(0,0,8'h00, 0,0,8'h00, 0);
        chk("alt_end_w0", 0, 32'(m0_waitrequest), 32'd1);

`ifdef ONEWIRE_ARB_LOCK_EN
        // m0 holds the grant across two writes and an idle cycle while m1 keeps requesting.
        cyc(0,1,8'hC1, 0,1,8'hD1, 1);
        chk("lk_a_write", 0, 32'(s_write), 32'd0);
        cyc(0,1,8'hC1, 0,1,8'hD1, 1);
        chk("lk_b_wdata", 1, s_writedata, 32'hC1);
        chk("lk_b_m0w",   1, 32'(m0_waitrequest), 32'd0);
        chk("lk_b_m1w",   1, 32'(m1_waitrequest), 32'd1);
        cyc(0,1,8'hC2, 0,1,8'hD1, 1);
        chk("lk_c_wdata", 2, s_writedata, 32'hC2);
        chk("lk_c_m1w",   2, 32'(m1_waitrequest), 32'd1);
        cyc(0,0,8'h00, 0,1,8'hD1, 1);
        chk("lk_d_write", 3, 32'(s_write), 32'd0);
        chk("lk_d_m1w",   3, 32'(m1_waitrequest), 32'd1);
        cyc(0,0,8'h00, 0,1,8'hD1, 0);
        chk("lk_e_m1w",   4, 32'(m1_waitrequest), 32'd1);
        cyc(0,0,8'h00, 0,1,8'hD1, 0);
        chk("lk_f_write", 5, 32'(s_write), 32'd0);
        cyc(0,0,8'h00, 0,1,8'hD1, 0);
        chk("lk_g_wdata", 6, s_writedata, 32'hD1);
        chk("lk_g_m1w",   6, 32'(m1_waitrequest), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
